// File: rtl/test_harness.sv
// -----------------------------------------------------------------------------
// test_harness
//
// Self-checking top level placed directly under the simulation driver. It owns
// a 2^ADDR_W x 32 single-port scratchpad and a sequencer that runs PASSES
// write/read-back passes using a 32-bit Galois LFSR data pattern. Odd passes
// write the complemented pattern so every bit is checked in both polarities.
// io_success rises only after every pass has verified cleanly. A mismatch
// parks the sequencer in a sticky FAIL state, and the driver's timeout then
// reports the failure.
//
// Parameters:
//   ADDR_W  scratchpad address width (depth N = 2^ADDR_W words)
//   PASSES  number of write/read-back passes (>= 1)
//   SEED    non-zero LFSR seed
//
// Ports:
//   clk         input   clock
//   reset       input   synchronous, active-low reset
//   io_success  output  high while the test has completed with no mismatch
//
// Optional build macro:
//   TEST_HARNESS_FAULT_INJECT_EN  inverts bit 0 of the word written to
//                                 address 5 during pass 0 so the read-back
//                                 fails (requires N > 5).
// -----------------------------------------------------------------------------
module test_harness #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned PASSES = 2,
  parameter logic [31:0] SEED   = 32'hACE1_0001
) (
  input  logic clk,
  input  logic reset,
  output logic io_success
);

  localparam int unsigned DEPTH  = 32'd1 << ADDR_W;
  localparam int unsigned PASS_W = (PASSES > 32'd1) ? $clog2(PASSES) : 32'd1;

  // One extra address bit so the end-of-phase value N is representable.
  localparam int unsigned LAST_ADDR_I = DEPTH - 32'd1;
  localparam logic [ADDR_W:0] ADDR_LAST = LAST_ADDR_I[ADDR_W:0];
  localparam logic [ADDR_W:0] ADDR_END  = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] ADDR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] ADDR_ZERO = {(ADDR_W+1){1'b0}};

  localparam int unsigned LAST_PASS_I = PASSES - 32'd1;
  localparam logic [PASS_W-1:0] PASS_LAST = LAST_PASS_I[PASS_W-1:0];
  localparam logic [PASS_W-1:0] PASS_ONE  = {{(PASS_W-1){1'b0}}, 1'b1};
  localparam logic [PASS_W-1:0] PASS_ZERO = {PASS_W{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DONE  = 3'd3,
    S_FAIL  = 3'd4
  } state_e;

  // Galois LFSR step, taps 0x0040_0007.
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    lfsr_next = {v[30:0], 1'b0} ^ (v[31] ? 32'h0040_0007 : 32'h0000_0000);
  endfunction

  state_e            state_q, state_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [ADDR_W:0]   addr_q, addr_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic              success_q, success_d;

  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       rdata_q;

  logic [31:0]       pattern_s;
  logic [31:0]       wdata_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic              mismatch_s;

  // Pattern for the current pass; the same value serves as write data and as
  // the read-back expectation because the LFSR is reseeded between phases.
  always_comb begin
    pattern_s  = lfsr_q ^ {32{pass_q[0]}};
    mem_addr_s = addr_q[ADDR_W-1:0];
    mismatch_s = (rdata_q != pattern_s);
  end

  // Write data, optionally corrupted at one location on the first pass.
  always_comb begin
`ifdef TEST_HARNESS_FAULT_INJECT_EN
    if ((state_q == S_WRITE) && (pass_q == PASS_ZERO) &&
        (addr_q == {{(ADDR_W-2){1'b0}}, 3'd5})) begin
      wdata_s = pattern_s ^ 32'h0000_0001;
    end else begin
      wdata_s = pattern_s;
    end
`else
    wdata_s = pattern_s;
`endif
  end

  // Sequencer next-state logic.
  always_comb begin
    state_d  = state_q;
    pass_d   = pass_q;
    addr_d   = addr_q;
    lfsr_d   = lfsr_q;
    mem_we_s = 1'b0;

    case (state_q)
      S_IDLE: begin
        lfsr_d  = SEED;
        pass_d  = PASS_ZERO;
        addr_d  = ADDR_ZERO;
        state_d = S_WRITE;
      end

      S_WRITE: begin
        mem_we_s = 1'b1;
        if (addr_q == ADDR_LAST) begin
          lfsr_d  = SEED;
          addr_d  = ADDR_ZERO;
          state_d = S_READ;
        end else begin
          lfsr_d = lfsr_next(lfsr_q);
          addr_d = addr_q + ADDR_ONE;
        end
      end

      // READ is an N+1 cycle pipeline: addr_q counts the cycle, a read of
      // addr_q is issued while addr_q < N, and the word read in the previous
      // cycle is compared whenever addr_q > 0.
      S_READ: begin
        if ((addr_q != ADDR_ZERO) && mismatch_s) begin
          state_d = S_FAIL;
        end else if (addr_q == ADDR_END) begin
          if (pass_q == PASS_LAST) begin
            state_d = S_DONE;
          end else begin
            pass_d  = pass_q + PASS_ONE;
            lfsr_d  = SEED;
            addr_d  = ADDR_ZERO;
            state_d = S_WRITE;
          end
        end else begin
          addr_d = addr_q + ADDR_ONE;
          if (addr_q != ADDR_ZERO) begin
            lfsr_d = lfsr_next(lfsr_q);
          end else begin
            lfsr_d = lfsr_q;
          end
        end
      end

      S_DONE: begin
        state_d = S_DONE;
      end

      S_FAIL: begin
        state_d = S_FAIL;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered alongside the state so io_success equals (state == DONE).
    success_d = (state_d == S_DONE);
  end

  // Sequencer state registers; reset overrides every transition.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pass_q    <= PASS_ZERO;
      addr_q    <= ADDR_ZERO;
      lfsr_q    <= SEED;
      success_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pass_q    <= pass_d;
      addr_q    <= addr_d;
      lfsr_q    <= lfsr_d;
      success_q <= success_d;
    end
  end

  // Single-port scratchpad with one-cycle registered read; contents are not
  // reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_addr_s] <= wdata_s;
    end
    rdata_q <= mem_q[mem_addr_s];
  end

  assign io_success = success_q;

endmodule

// File: tb/tb_test_harness.sv
// -----------------------------------------------------------------------------
// Bench for test_harness. Three instances with different parameter sets share
// one clock and reset. A behavioural model replays the memory test with plain
// arrays to find the edge (counted from reset release) at which each instance
// must report success, or that it never may. Reset pulses land at randomised
// points, including mid-pass and in DONE.
// -----------------------------------------------------------------------------
module tb_test_harness;

  localparam logic [31:0] SEED = 32'hACE1_0001;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic succ_def, succ_small, succ_mid;

  int n_checks = 0;
  int n_pass   = 0;
  int rel_edge = 0;
  int done_def, done_small, done_mid;

  always #5 clk = ~clk;

  test_harness #(.ADDR_W(8), .PASSES(2), .SEED(SEED)) u_def (
    .clk(clk), .reset(reset), .io_success(succ_def));
  test_harness #(.ADDR_W(4), .PASSES(1), .SEED(SEED)) u_small (
    .clk(clk), .reset(reset), .io_success(succ_small));
  test_harness #(.ADDR_W(6), .PASSES(3), .SEED(SEED)) u_mid (
    .clk(clk), .reset(reset), .io_success(succ_mid));

  function automatic logic [31:0] ref_lfsr(input logic [31:0] v);
    return (v << 1) ^ (v[31] ? 32'h0040_0007 : 32'h0000_0000);
  endfunction

  // Replays every pass on an array; returns the edge that enters DONE, or -1.
  function automatic int model_done_edge(input int aw, input int passes);
    int n;
    int cnt;
    logic [31:0] mem [];
    logic [31:0] l;
    logic [31:0] m;
    logic [31:0] w;
    n   = 1 << aw;
    mem = new[n];
    cnt = 1;                       // the IDLE edge
    for (int p = 0; p < passes; p++) begin
      m = (p % 2 == 1) ? 32'hFFFF_FFFF : 32'h0000_0000;
      l = SEED;
      for (int a = 0; a < n; a++) begin
        w = l ^ m;
`ifdef TEST_HARNESS_FAULT_INJECT_EN
        if (p == 0 && a == 5) w[0] = ~w[0];
`endif
        mem[a] = w;
        l = ref_lfsr(l);
      end
      cnt += n;
      cnt += 1;                    // first read cycle: issue only
      l = SEED;
      for (int a = 0; a < n; a++) begin
        if (mem[a] !== (l ^ m)) return -1;
        l = ref_lfsr(l);
        cnt += 1;
      end
    end
    return cnt;
  endfunction

  function automatic logic [2:0] model_vec(input int e);
    logic [2:0] v;
    v[0] = (e > 0) && (done_def   > 0) && (e >= done_def);
    v[1] = (e > 0) && (done_small > 0) && (e >= done_small);
    v[2] = (e > 0) && (done_mid   > 0) && (e >= done_mid);
    return v;
  endfunction

  // One clock; rel_edge numbers edges that sample reset high since release.
  task automatic step();
    @(posedge clk);
    if (reset) rel_edge++;
    else       rel_edge = 0;
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] exp;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      exp = model_vec(rel_edge);
      n_checks++;
      if ({succ_mid, succ_small, succ_def} !== exp)
        $display("FAIL reset: got %b want %b", {succ_mid, succ_small, succ_def}, exp);
      else n_pass++;
    end
  endtask

  task automatic test_full_run();
    logic [2:0] exp;
    int guard;
    reset = 1'b1;
    guard = 0;
    while (rel_edge < done_def + 1000 && guard < 4000) begin
      step();
      guard++;
      exp = model_vec(rel_edge);
      n_checks++;
      if ({succ_mid, succ_small, succ_def} !== exp)
        $display("FAIL full_run edge %0d: got %b want %b", rel_edge,
                 {succ_mid, succ_small, succ_def}, exp);
      else n_pass++;
    end
  endtask

  // Fresh release, reset pulsed at edge 'at' for 'hold' cycles, then run on.
  task automatic test_reset_mid_pass(input int at, input int hold);
    logic [2:0] exp;
    int guard;
    reset = 1'b0;
    step();
    reset = 1'b1;
    guard = 0;
    while (rel_edge < at && guard < 4000) begin
      step();
      guard++;
      exp = model_vec(rel_edge);
      n_checks++;
      if ({succ_mid, succ_small, succ_def} !== exp)
        $display("FAIL mid_pass_pre edge %0d: got %b want %b", rel_edge,
                 {succ_mid, succ_small, succ_def}, exp);
      else n_pass++;
    end
    reset = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      exp = model_vec(rel_edge);
      n_checks++;
      if ({succ_mid, succ_small, succ_def} !== exp)
        $display("FAIL mid_pass_hold: got %b want %b",
                 {succ_mid, succ_small, succ_def}, exp);
      else n_pass++;
    end
    reset = 1'b1;
    guard = 0;
    while (rel_edge < done_def + 20 && guard < 4000) begin
      step();
      guard++;
      exp = model_vec(rel_edge);
      n_checks++;
      if ({succ_mid, succ_small, succ_def} !== exp)
        $display("FAIL mid_pass_post edge %0d: got %b want %b", rel_edge,
                 {succ_mid, succ_small, succ_def}, exp);
      else n_pass++;
    end
  endtask

  // Starts from a completed run, pulses reset once and reruns to completion.
  task automatic test_reset_in_done();
    logic [2:0] exp;
    int guard;
    reset = 1'b0;
    step();
    exp = model_vec(rel_edge);
    n_checks++;
    if ({succ_mid, succ_small, succ_def} !== exp)
      $display("FAIL done_drop: got %b want %b", {succ_mid, succ_small, succ_def}, exp);
    else n_pass++;
    reset = 1'b1;
    guard = 0;
    while (rel_edge < done_def + 5 && guard < 4000) begin
      step();
      guard++;
      exp = model_vec(rel_edge);
      n_checks++;
      if ({succ_mid, succ_small, succ_def} !== exp)
        $display("FAIL done_rerun edge %0d: got %b want %b", rel_edge,
                 {succ_mid, succ_small, succ_def}, exp);
      else n_pass++;
    end
  endtask

  initial begin
    done_def   = model_done_edge(8, 2);
    done_small = model_done_edge(4, 1);
    done_mid   = model_done_edge(6, 3);

    test_reset();
    test_full_run();
    test_reset_mid_pass(300, 1);
    test_reset_in_done();
    for (int k = 0; k < 3; k++) begin
      test_reset_mid_pass($urandom_range(2, 1030), $urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
